// File: rtl/inst_fetch.sv
// Instruction fetch: PC, credit-limited imem requests, in-order response FIFO to decode, redirect flush.
// Response to decode in 1 cycle; requests stop once in-flight plus buffered entries reach FIFO_DEPTH.
module inst_fetch #(
  parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        Clk,
  input  logic        RstN,
  output logic        ImemReqValid,
  input  logic        ImemReqReady,
  output logic [63:0] ImemReqAddr,
  input  logic        ImemRespValid,
  input  logic [31:0] ImemRespData,
  input  logic        RedirectValid,
  input  logic [63:0] RedirectAddr,
  output logic        InstValidOut,
  input  logic        InstReady,
  output logic [63:0] InstAddrOut,
  output logic [31:0] InstOut
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] inst;
  } entry_t;

  logic [63:0]   pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] inflight_next;
  logic [CW-1:0] discard;
  logic [CW-1:0] count;

  logic [63:0]   aq_mem [FIFO_DEPTH];
  logic [AW-1:0] aq_wr;
  logic [AW-1:0] aq_rd;

  entry_t        fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] fifo_wr;
  logic [AW-1:0] fifo_rd;
  entry_t        push_ent;
  entry_t        head_ent;

  logic fire;
  logic push;
  logic pop;
  logic unused_redirect_lsbs;

  // Credit uses registered state only, so no input reaches ImemReqValid.
  assign ImemReqValid  = ({1'b0, inflight} + {1'b0, count}) < (CW+1)'(FIFO_DEPTH);
  assign ImemReqAddr   = pc;
  assign fire          = ImemReqValid && ImemReqReady;
  assign push          = ImemRespValid && (discard == '0) && !RedirectValid;
  assign pop           = InstValidOut && InstReady;
  assign inflight_next = inflight + CW'(fire) - CW'(ImemRespValid);

  assign push_ent.addr = aq_mem[aq_rd];
  assign push_ent.inst = ImemRespData;
  assign head_ent      = fifo_mem[fifo_rd];
  assign InstValidOut  = (count != '0);
  assign InstAddrOut   = head_ent.addr;
  assign InstOut       = head_ent.inst;

  assign unused_redirect_lsbs = ^RedirectAddr[1:0];

  always_ff @(posedge Clk) begin
    if (!RstN) begin
      pc       <= {RESET_PC[63:2], 2'b00};
      inflight <= '0;
      discard  <= '0;
      count    <= '0;
      aq_wr    <= '0;
      aq_rd    <= '0;
      fifo_wr  <= '0;
      fifo_rd  <= '0;
    end else begin
      inflight <= inflight_next;
      // The address queue tracks every outstanding request, stale or live.
      if (fire)          aq_wr <= aq_wr + 1'b1;
      if (ImemRespValid) aq_rd <= aq_rd + 1'b1;
      if (RedirectValid) begin
        pc      <= {RedirectAddr[63:2], 2'b00};
        discard <= inflight_next;
        count   <= '0;
        fifo_wr <= '0;
        fifo_rd <= '0;
      end else begin
        if (fire) pc <= pc + 64'd4;
        if (ImemRespValid && (discard != '0)) discard <= discard - 1'b1;
        if (push) fifo_wr <= fifo_wr + 1'b1;
        if (pop)  fifo_rd <= fifo_rd + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (fire) aq_mem[aq_wr]     <= pc;
    if (push) fifo_mem[fifo_wr] <= push_ent;
  end

  overflow_chk: assert property (@(posedge Clk) disable iff (!RstN)
    !(push && !pop && (count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios then random traffic, checked against an epoch-based stream model.
module tb_inst_fetch;
  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        RstN;
  logic        ImemReqValid;
  logic        ImemReqReady;
  logic [63:0] ImemReqAddr;
  logic        ImemRespValid;
  logic [31:0] ImemRespData;
  logic        RedirectValid;
  logic [63:0] RedirectAddr;
  logic        InstValidOut;
  logic        InstReady;
  logic [63:0] InstAddrOut;
  logic [31:0] InstOut;

  int total = 0;
  int bad   = 0;

  inst_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .Clk(Clk), .RstN(RstN),
    .ImemReqValid(ImemReqValid), .ImemReqReady(ImemReqReady), .ImemReqAddr(ImemReqAddr),
    .ImemRespValid(ImemRespValid), .ImemRespData(ImemRespData),
    .RedirectValid(RedirectValid), .RedirectAddr(RedirectAddr),
    .InstValidOut(InstValidOut), .InstReady(InstReady),
    .InstAddrOut(InstAddrOut), .InstOut(InstOut)
  );

  always #5 Clk = ~Clk;

  // Outstanding memory requests carry the redirect epoch they were issued in.
  typedef struct {
    logic [63:0] addr;
    int          epoch;
    int          due;
  } req_t;
  typedef struct {
    logic [63:0] addr;
    logic [31:0] inst;
  } ent_t;

  req_t        pend[$];
  ent_t        expq[$];
  logic [63:0] mpc = RST_PC;
  int          epoch = 0;
  int          cyc = 0;
  int          lat = 1;
  int          fires_seen = 0;
  bit          chk_en = 0;

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0];
  endfunction

  function automatic bit model_credit();
    return (pend.size() + expq.size()) < DEPTH;
  endfunction

  function automatic bit resp_due();
    return (pend.size() != 0) && (pend[0].due <= cyc);
  endfunction

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit rready, input bit iready,
                      input bit redir, input logic [63:0] raddr);
    bit   credit, fire, resp, pop;
    req_t r;
    ent_t e;
    RstN          = !rst;
    ImemReqReady  = rready;
    InstReady     = iready;
    RedirectValid = redir;
    RedirectAddr  = raddr;
    resp          = !rst && resp_due();
    ImemRespValid = resp;
    ImemRespData  = resp ? word_of(pend[0].addr) : 32'($urandom);
    credit        = model_credit();
    fire          = credit && rready;
    pop           = (expq.size() != 0) && iready;
    if (chk_en) begin
      check("req_vld", 96'(ImemReqValid), 96'(credit));
      check("req_addr", 96'(ImemReqAddr), 96'(mpc));
      check("inst_vld", 96'(InstValidOut), 96'(expq.size() != 0));
      if (expq.size() != 0) begin
        check("inst_addr", 96'(InstAddrOut), 96'(expq[0].addr));
        check("inst_dat", 96'(InstOut), 96'(expq[0].inst));
      end
    end
    if (ImemReqValid === 1'b1 && rready) fires_seen++;
    @(posedge Clk);
    if (rst) begin
      pend.delete();
      expq.delete();
      mpc    = RST_PC;
      epoch  = 0;
      chk_en = 1;
    end else begin
      if (pop) expq.delete(0);
      if (resp) begin
        r = pend.pop_front();
        if (!redir && r.epoch == epoch) begin
          e.addr = r.addr;
          e.inst = word_of(r.addr);
          expq.push_back(e);
        end
      end
      if (fire) begin
        r.addr  = mpc;
        r.epoch = epoch;
        r.due   = cyc + lat;
        pend.push_back(r);
        mpc = mpc + 64'd4;
      end
      if (redir) begin
        epoch++;
        expq.delete();
        mpc = {raddr[63:2], 2'b00};
      end
    end
    cyc++;
    @(negedge Clk);
  endtask

  initial begin
    bit found;
    RstN = 1'b0; ImemReqReady = 1'b0; InstReady = 1'b0;
    RedirectValid = 1'b0; RedirectAddr = '0;
    ImemRespValid = 1'b0; ImemRespData = '0;
    @(negedge Clk);

    // Reset, streaming at L=1 with word = address
    step(1, 0, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    check("rst_req_vld", 96'(ImemReqValid), 96'(1));
    check("rst_req_addr", 96'(ImemReqAddr), 96'(RST_PC));
    check("rst_inst_vld", 96'(InstValidOut), 96'(0));
    lat = 1;
    step(0, 1, 1, 0, '0);
    check("first_not_yet", 96'(InstValidOut), 96'(0));
    step(0, 1, 1, 0, '0);
    check("first_vld", 96'(InstValidOut), 96'(1));
    check("first_addr", 96'(InstAddrOut), 96'(RST_PC));
    check("first_dat", 96'(InstOut), 96'(32'h8000_0000));
    for (int i = 0; i < 12; i++) step(0, 1, 1, 0, '0);

    // Decode stall from empty: exactly DEPTH requests fire
    step(1, 0, 0, 0, '0);
    fires_seen = 0;
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, '0);
    check("stall_fires", 96'(fires_seen), 96'(DEPTH));
    check("stall_req_vld", 96'(ImemReqValid), 96'(0));
    check("stall_count", 96'(dut.count), 96'(DEPTH));
    for (int i = 0; i < 10; i++) step(0, 1, 1, 0, '0);

    // L=3 redirect with three requests in flight
    step(1, 0, 0, 0, '0);
    lat = 3;
    step(0, 1, 1, 0, '0);
    step(0, 1, 1, 0, '0);
    step(0, 1, 1, 1, 64'h0000_0000_8000_1002);
    check("redir_addr", 96'(ImemReqAddr), 96'(64'h0000_0000_8000_1000));
    check("redir_inst_vld", 96'(InstValidOut), 96'(0));
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (InstValidOut === 1'b1) found = 1;
      else step(0, 1, 1, 0, '0);
    end
    check("redir_first_seen", 96'(found), 96'(1));
    if (found) begin
      check("redir_first_addr", 96'(InstAddrOut), 96'(64'h0000_0000_8000_1000));
      check("redir_first_dat", 96'(InstOut), 96'(32'h8000_1000));
    end
    for (int i = 0; i < 6; i++) step(0, 1, 1, 0, '0);

    // Redirect coinciding with a fire and a response
    lat = 1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (resp_due() && model_credit()) found = 1;
      else step(0, 1, 1, 0, '0);
    end
    check("coincide_setup", 96'(found), 96'(1));
    step(0, 1, 1, 1, 64'h0000_0000_9000_0000);
    check("coincide_inst_vld", 96'(InstValidOut), 96'(0));
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, '0);
    check("drain_inflight", 96'(dut.inflight), 96'(0));
    check("drain_discard", 96'(dut.discard), 96'(0));
    check("drain_inst_vld", 96'(InstValidOut), 96'(0));
    for (int i = 0; i < 6; i++) step(0, 1, 1, 0, '0);

    // Reset pulse mid-stream with a non-empty FIFO
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, '0);
    check("pre_rst_vld", 96'(InstValidOut), 96'(1));
    step(1, 1, 0, 0, '0);
    check("mid_rst_inst_vld", 96'(InstValidOut), 96'(0));
    check("mid_rst_req_addr", 96'(ImemReqAddr), 96'(RST_PC));
    check("mid_rst_req_vld", 96'(ImemReqValid), 96'(1));
    check("mid_rst_inflight", 96'(dut.inflight), 96'(0));
    check("mid_rst_discard", 96'(dut.discard), 96'(0));
    check("mid_rst_count", 96'(dut.count), 96'(0));
    for (int i = 0; i < 6; i++) step(0, 1, 1, 0, '0);

    // PC wrap at the top of the address space
    step(1, 0, 0, 0, '0);
    step(0, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    check("wrap_start", 96'(ImemReqAddr), 96'(64'hFFFF_FFFF_FFFF_FFFC));
    step(0, 1, 1, 0, '0);
    check("wrap_zero", 96'(ImemReqAddr), 96'(64'h0));
    for (int i = 0; i < 6; i++) step(0, 1, 1, 0, '0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      lat = $urandom_range(1, 4);
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0,
           {32'($urandom), 32'($urandom)});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
